// File: rtl/pp_pipeline_accel_fifo_wr_arb_if.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_fifo_wr_arb_if
// Bundles the producer-side request bus, the shared FIFO write port and the
// grant status of the FIFO write arbiter.
//   enable      : permits new grants
//   req_valid   : per-requester beat valid            [NUM_REQ]
//   req_last    : per-requester end-of-burst marker   [NUM_REQ]
//   req_data    : packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   : per-requester accept                [NUM_REQ]
//   fifo_din    : data to FIFO write port
//   fifo_write  : FIFO write strobe
//   fifo_full_n : FIFO not-full
//   gnt_valid   : a grant is held
//   gnt_id      : index of the granted requester
//   busy        : arbiter is not idle
// Modports: slave = the arbiter, master = whoever drives producers / FIFO.
// ---------------------------------------------------------------------------
interface pp_pipeline_accel_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
);
  logic                          enable;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_write;
  logic                          fifo_full_n;
  logic                          gnt_valid;
  logic [ID_WIDTH-1:0]           gnt_id;
  logic                          busy;

  modport slave (
    input  enable, req_valid, req_last, req_data, fifo_full_n,
    output req_ready, fifo_din, fifo_write, gnt_valid, gnt_id, busy
  );

  modport master (
    output enable, req_valid, req_last, req_data, fifo_full_n,
    input  req_ready, fifo_din, fifo_write, gnt_valid, gnt_id, busy
  );
endinterface

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_fifo_wr_arb
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ
// producers. A grant is held for a whole burst (up to BURST_MAX beats or
// until req_last), so bursts from different producers never interleave.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset (release synchronous to clk)
//   arb_if  : request bus / FIFO write port / grant status (slave modport)
// ---------------------------------------------------------------------------
module pp_pipeline_accel_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic clk,
  input  logic reset_n,
  pp_pipeline_accel_fifo_wr_arb_if.slave arb_if
);

  // Counter only has to reach BURST_MAX-1; keep at least one bit.
  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_d;
  logic [ID_WIDTH-1:0] last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    ready_vec;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [ID_WIDTH-1:0]   idx;
  logic                  granted;
  logic                  xfer;
  logic                  burst_end;

  assign granted = (state_q == GRANT);

  // Unpack payloads and build the one-hot ready vector.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign data_arr[gi]  = arb_if.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ready_vec[gi] = granted && (gnt_id_q == ID_WIDTH'(gi)) && arb_if.fifo_full_n;
  end

  // Round-robin pick: search starts just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(last_gnt_q) + k) % NUM_REQ);
      if (!pick_found && arb_if.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // FIFO port and status, purely from registered grant state.
  assign xfer      = granted && arb_if.req_valid[gnt_id_q] && arb_if.fifo_full_n;
  assign burst_end = arb_if.req_last[gnt_id_q] || (beat_cnt_q == CNT_W'(BURST_MAX - 1));

  assign arb_if.req_ready  = ready_vec;
  assign arb_if.fifo_write = xfer;
  assign arb_if.fifo_din   = granted ? data_arr[gnt_id_q] : '0;
  assign arb_if.gnt_valid  = granted;
  assign arb_if.busy       = granted;
  assign arb_if.gnt_id     = gnt_id_q;

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_if.enable && pick_found) begin
          state_d    = GRANT;
          gnt_id_d   = pick_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        // Stalls (full or valid gap) simply hold here; no timeout.
        if (xfer) begin
          if (burst_end) begin
            // Clear instead of incrementing so the count never wraps.
            beat_cnt_d = '0;
            last_gnt_d = gnt_id_q;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      last_gnt_q <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_pp_pipeline_accel_fifo_wr_arb
// Directed bench for the round-robin FIFO write arbiter (4 requesters,
// 64-bit data, 8-beat bursts). Inputs change 1 ns after a rising edge and
// outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_pp_pipeline_accel_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int BM = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  pp_pipeline_accel_fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  pp_pipeline_accel_fifo_wr_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM), .ID_WIDTH(IW)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .arb_if (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] dval(input int r, input int b);
    return {8'(r), 24'hA5A5A5, 32'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int b);
    for (int r = 0; r < NR; r++) bus.req_data[r*DW +: DW] = dval(r, b);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  64'(bus.busy), 64'd0);
    check({tag, ".gntv"},  64'(bus.gnt_valid), 64'd0);
    check({tag, ".write"}, 64'(bus.fifo_write), 64'd0);
    check({tag, ".ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  task automatic check_beat(input string tag, input int id, input logic [DW-1:0] d);
    check({tag, ".gntv"},  64'(bus.gnt_valid), 64'd1);
    check({tag, ".id"},    64'(bus.gnt_id), 64'(id));
    check({tag, ".write"}, 64'(bus.fifo_write), 64'd1);
    check({tag, ".din"},   bus.fifo_din, d);
    check({tag, ".ready"}, 64'(bus.req_ready), 64'(1 << id));
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // ---------------- reset state ----------------
    reset_n         = 1'b0;
    bus.enable      = 1'b1;
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.req_data    = '0;
    bus.fifo_full_n = 1'b1;
    #2;
    check_idle("rst");
    check("rst.din", bus.fifo_din, 64'd0);
    check("rst.id",  64'(bus.gnt_id), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---------------- T1: single requester, 3-beat burst ----------------
    bus.req_valid = 4'b0001;
    set_data(1);
    #1;
    check_idle("t1.arb");
    tick();
    for (int b = 1; b <= 3; b++) begin
      set_data(b);
      bus.req_last = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      check_beat($sformatf("t1.b%0d", b), 0, dval(0, b));
      tick();
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    #1;
    check_idle("t1.end");

    // ---------------- T2: all valid, forced rotation at 8 beats ----------------
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check_idle($sformatf("t2.g%0d.bubble", g));
      tick();
      for (int b = 1; b <= BM; b++) begin
        set_data(b);
        #1;
        check_beat($sformatf("t2.g%0d.b%0d", g, b), order[g], dval(order[g], b));
        tick();
      end
    end
    bus.req_valid = '0;
    #1;
    check_idle("t2.end");

    // ---------------- T3: requester 2, FIFO full stall after beat 4 ----------------
    bus.req_valid = 4'b0100;
    tick();
    for (int b = 1; b <= 4; b++) begin
      set_data(b);
      #1;
      check_beat($sformatf("t3.b%0d", b), 2, dval(2, b));
      tick();
    end
    set_data(5);
    bus.fifo_full_n = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("t3.stall%0d.write", s), 64'(bus.fifo_write), 64'd0);
      check($sformatf("t3.stall%0d.ready", s), 64'(bus.req_ready), 64'd0);
      check($sformatf("t3.stall%0d.id", s),    64'(bus.gnt_id), 64'd2);
      check($sformatf("t3.stall%0d.gntv", s),  64'(bus.gnt_valid), 64'd1);
      tick();
    end
    bus.fifo_full_n = 1'b1;
    for (int b = 5; b <= BM; b++) begin
      set_data(b);
      #1;
      check_beat($sformatf("t3.b%0d", b), 2, dval(2, b));
      tick();
    end
    bus.req_valid = '0;
    #1;
    check_idle("t3.end");

    // ---------------- T4: single-beat burst, then valid gap on requester 1 ----------------
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b1000;
    set_data(1);
    tick();
    #1;
    check_beat("t4.r3single", 3, dval(3, 1));
    tick();
    bus.req_valid = 4'b1010;
    bus.req_last  = 4'b0000;
    #1;
    check_idle("t4.arb");
    tick();
    for (int b = 1; b <= 2; b++) begin
      set_data(b);
      #1;
      check_beat($sformatf("t4.b%0d", b), 1, dval(1, b));
      tick();
    end
    bus.req_valid = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("t4.gap%0d.write", s), 64'(bus.fifo_write), 64'd0);
      check($sformatf("t4.gap%0d.ready", s), 64'(bus.req_ready), 64'b0010);
      check($sformatf("t4.gap%0d.id", s),    64'(bus.gnt_id), 64'd1);
      tick();
    end
    bus.req_valid = 4'b1010;
    bus.req_last  = 4'b0010;
    set_data(3);
    #1;
    check_beat("t4.b3", 1, dval(1, 3));
    tick();
    bus.req_last = 4'b0000;
    #1;
    check_idle("t4.mid");
    tick();
    bus.req_last = 4'b1000;
    #1;
    check_beat("t4.r3next", 3, dval(3, 3));
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;

    // ---------------- T5: enable dropped during requester 0's burst ----------------
    bus.req_valid = 4'b0011;
    set_data(1);
    tick();
    #1;
    check_beat("t5.b1", 0, dval(0, 1));
    tick();
    bus.enable   = 1'b0;
    bus.req_last = 4'b0001;
    set_data(2);
    #1;
    check_beat("t5.b2", 0, dval(0, 2));
    tick();
    bus.req_last = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_idle($sformatf("t5.dis%0d", s));
      tick();
    end
    bus.enable = 1'b1;
    tick();
    bus.req_last = 4'b0010;
    #1;
    check_beat("t5.r1", 1, dval(1, 2));
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;

    // ---------------- T6: async reset in the middle of a burst ----------------
    bus.req_valid = 4'b0100;
    set_data(1);
    tick();
    #1;
    check_beat("t6.b1", 2, dval(2, 1));
    tick();
    set_data(2);
    #1;
    check_beat("t6.b2", 2, dval(2, 2));
    reset_n = 1'b0;
    #1;
    check_idle("t6.rst");
    check("t6.rst.din", bus.fifo_din, 64'd0);
    tick();
    reset_n = 1'b1;
    bus.req_valid = 4'b0101;
    #1;
    check_idle("t6.arb");
    tick();
    #1;
    check_beat("t6.regrant", 0, dval(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
